// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared memory-port types and arbiter state encoding
package mem_arbiter_pkg;
   localparam int N_CORES_DEFAULT = 4;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   typedef struct packed {
      logic              cs;
      logic              rw;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } memory_request_t;
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              ready;
   } memory_response_t;
   typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RELEASE} arb_state_t;
   typedef logic [$clog2(N_CORES_DEFAULT)-1:0] core_id_t;
endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// rr_picker: combinational round-robin priority encoder, first set bit at or after ptr
module rr_picker #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] win,
   output logic         any
);
   logic [W-1:0] idx;
   // scan from farthest to nearest so the candidate closest to ptr is written last
   always_comb begin
      win = '0;
      any = 1'b0;
      idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = W'((int'(ptr) + k) % N);
         if (req[idx]) begin
            win = idx;
            any = 1'b1;
         end
      end
   end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of the single mem_ctrl port between N_CORES caches
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int N_CORES        = N_CORES_DEFAULT,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                       clk,
   input  logic                       rst,
   input  memory_request_t            cache_mem_req [N_CORES],
   output memory_response_t           cache_mem_res [N_CORES],
   output memory_request_t            mem_req,
   input  memory_response_t           mem_res,
   output logic [$clog2(N_CORES)-1:0] grant_id,
   output logic                       busy,
   output logic                       timeout_err
);
   localparam int ID_W = $clog2(N_CORES);
   localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_CORES - 1);

   arb_state_t      state_q, state_d;
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0] grant_id_q, grant_id_d;
   memory_request_t req_q, req_d;
   logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
   logic [N_CORES-1:0] cs_vec;
   logic [ID_W-1:0] win;
   logic            any;
   logic            done;
   logic            expire;

   // gather chip selects for the picker
   always_comb begin
      cs_vec = '0;
      for (int i = 0; i < N_CORES; i++) cs_vec[i] = cache_mem_req[i].cs;
   end

   rr_picker #(.N(N_CORES), .W(ID_W)) u_pick (
      .req (cs_vec),
      .ptr (rr_ptr_q),
      .win (win),
      .any (any)
   );

   assign done   = (state_q == ARB_BUSY) && mem_res.ready;
   assign expire = (TIMEOUT_CYCLES != 0) && (state_q == ARB_BUSY) && !mem_res.ready && (wd_cnt_q == WD_LAST);

   // next state: grant in IDLE, finish on ready or watchdog, one RELEASE cycle back to IDLE
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      grant_id_d = grant_id_q;
      req_d      = req_q;
      wd_cnt_d   = wd_cnt_q;
      if (state_q == ARB_IDLE && any) begin
         state_d    = ARB_BUSY;
         grant_id_d = win;
         req_d      = cache_mem_req[win];
         wd_cnt_d   = '0;
      end else if (done || expire) begin
         state_d  = ARB_RELEASE;
         rr_ptr_d = (grant_id_q == LAST_ID) ? '0 : grant_id_q + 1'b1;
      end else if (state_q == ARB_BUSY) begin
         wd_cnt_d = wd_cnt_q + 1'b1;
      end else if (state_q == ARB_RELEASE) begin
         state_d = ARB_IDLE;
      end
   end

   // arbiter registers; reset abandons any transaction in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ARB_IDLE;
         rr_ptr_q   <= '0;
         grant_id_q <= '0;
         req_q      <= '0;
         wd_cnt_q   <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_id_q <= grant_id_d;
         req_q      <= req_d;
         wd_cnt_q   <= wd_cnt_d;
      end
   end

   // forward the latched request and route the response to the owner only
   always_comb begin
      mem_req    = req_q;
      mem_req.cs = (state_q == ARB_BUSY);
      for (int i = 0; i < N_CORES; i++) begin
         cache_mem_res[i].data  = mem_res.data;
         cache_mem_res[i].ready = done && (grant_id_q == ID_W'(i));
      end
   end

   assign busy        = (state_q == ARB_BUSY);
   assign grant_id    = grant_id_q;
   assign timeout_err = expire;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random stimulus against a transaction-level arbiter model
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;
   localparam int N  = 4;
   localparam int TO = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   memory_request_t  cmreq [N];
   memory_response_t cmres [N];
   memory_request_t  mreq;
   memory_response_t mres;
   logic [1:0] grant_id;
   logic busy, timeout_err;

   always #5 clk = ~clk;

   mem_arbiter #(.N_CORES(N), .TIMEOUT_CYCLES(TO)) dut (
      .clk           (clk),
      .rst           (rst),
      .cache_mem_req (cmreq),
      .cache_mem_res (cmres),
      .mem_req       (mreq),
      .mem_res       (mres),
      .grant_id      (grant_id),
      .busy          (busy),
      .timeout_err   (timeout_err)
   );

   int checks = 0;
   int errors = 0;

   logic [N-1:0] want;
   logic         rw_v [N];
   logic [31:0]  addr_v [N];
   logic [31:0]  data_v [N];
   int mode;
   int lat;

   int owner = -1;
   int ptr = 0;
   int age = 0;
   bit rel = 0;
   memory_request_t lreq;
   int n_to = 0;
   int rdy_cnt [N];
   int order [$];
   bit prev_busy = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         cmreq[i].cs   = want[i];
         cmreq[i].rw   = rw_v[i];
         cmreq[i].addr = addr_v[i];
         cmreq[i].data = data_v[i];
      end
      mres.data  = $urandom;
      mres.ready = (mode == 0) ? ($urandom_range(0, 3) == 0) :
                   (mode == 1) ? (owner >= 0 && age == lat - 1) : 1'b0;
   endtask

   task automatic check_outputs();
      bit eb;
      bit et;
      eb = owner >= 0;
      et = eb && !mres.ready && age == TO - 1;
      check("busy", busy, eb);
      check("cs", mreq.cs, eb);
      if (eb) begin
         check("grant", grant_id, owner);
         check("addr", mreq.addr, lreq.addr);
         check("wdata", mreq.data, lreq.data);
         check("rw", mreq.rw, lreq.rw);
      end
      check("timeout", timeout_err, et);
      for (int i = 0; i < N; i++) begin
         check($sformatf("ready%0d", i), cmres[i].ready, eb && owner == i && mres.ready);
         if (eb && owner == i && mres.ready) check("rdata", cmres[i].data, mres.data);
         if (cmres[i].ready) rdy_cnt[i]++;
      end
      if (timeout_err) n_to++;
      if (busy && !prev_busy) order.push_back(int'(grant_id));
      prev_busy = busy;
   endtask

   task automatic update();
      if (owner >= 0) begin
         if (mres.ready) begin
            want[owner] = 1'b0;
            ptr = (owner + 1) % N;
            owner = -1;
            rel = 1;
         end else if (age == TO - 1) begin
            ptr = (owner + 1) % N;
            owner = -1;
            rel = 1;
         end else age++;
      end else if (rel) rel = 0;
      else begin
         for (int k = 0; k < N; k++) begin
            int c;
            c = (ptr + k) % N;
            if (owner < 0 && cmreq[c].cs) begin
               owner = c;
               age = 0;
               lreq = cmreq[c];
            end
         end
      end
   endtask

   task automatic cycle();
      drive();
      @(negedge clk);
      check_outputs();
      update();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_obs();
      order.delete();
      prev_busy = 0;
      n_to = 0;
      for (int i = 0; i < N; i++) rdy_cnt[i] = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      want = '0;
      owner = -1;
      rel = 0;
      ptr = 0;
      age = 0;
      drive();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      clear_obs();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      want = '0;
      mode = 1;
      lat = 3;
      for (int i = 0; i < N; i++) begin
         rw_v[i] = 1'b0;
         addr_v[i] = '0;
         data_v[i] = '0;
      end
      clear_obs();
      drive();
      mres.ready = 1'b1;
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_cs", mreq.cs, 0);
      check("rst_grant", grant_id, 0);
      check("rst_timeout", timeout_err, 0);
      for (int i = 0; i < N; i++) check($sformatf("rst_ready%0d", i), cmres[i].ready, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      addr_v[0] = 32'h10;
      rw_v[0] = 1'b0;
      want[0] = 1'b1;
      repeat (8) cycle();
      check("t1_grants", order.size(), 1);
      check("t1_owner", (order.size() > 0) ? order[0] : -1, 0);
      check("t1_ready0", rdy_cnt[0], 1);
      for (int i = 1; i < N; i++) check($sformatf("t1_ready%0d", i), rdy_cnt[i], 0);

      do_reset();
      for (int i = 0; i < N; i++) addr_v[i] = 32'h100 + i;
      want = '1;
      lat = 2;
      repeat (30) cycle();
      check("t2_grants", order.size(), 4);
      for (int i = 0; i < N; i++) check($sformatf("t2_order%0d", i), (order.size() > i) ? order[i] : -1, i);

      clear_obs();
      want[2] = 1'b1;
      repeat (8) cycle();
      want[2] = 1'b1;
      want[3] = 1'b1;
      repeat (16) cycle();
      check("t3_grants", order.size(), 3);
      check("t3_first", (order.size() > 1) ? order[1] : -1, 3);
      check("t3_second", (order.size() > 2) ? order[2] : -1, 2);

      clear_obs();
      addr_v[0] = 32'h20;
      data_v[0] = 32'hAAAA;
      rw_v[0] = 1'b1;
      want[0] = 1'b1;
      lat = 6;
      repeat (2) cycle();
      addr_v[0] = 32'h30;
      data_v[0] = 32'h5555;
      rw_v[0] = 1'b0;
      repeat (3) cycle();
      check("t4_busy", busy, 1);
      check("t4_addr", mreq.addr, 32'h20);
      repeat (6) cycle();
      check("t4_done", rdy_cnt[0], 1);

      clear_obs();
      mode = 2;
      want[1] = 1'b1;
      want[2] = 1'b1;
      repeat (20) cycle();
      check("t5_timeouts", n_to, 1);
      check("t5_first", (order.size() > 0) ? order[0] : -1, 1);
      check("t5_next", (order.size() > 1) ? order[1] : -1, 2);
      check("t5_noready", rdy_cnt[1], 0);
      mode = 1;
      lat = TO;
      repeat (40) cycle();
      check("t5_tie_timeouts", n_to, 1);
      check("t5_ready2", rdy_cnt[2], 1);
      check("t5_ready1", rdy_cnt[1], 1);

      clear_obs();
      mode = 2;
      want[1] = 1'b1;
      repeat (4) cycle();
      check("t6_busy_before", busy, 1);
      mres.ready = 1'b1;
      rst = 1'b1;
      #1;
      check("t6_busy", busy, 0);
      check("t6_cs", mreq.cs, 0);
      check("t6_grant", grant_id, 0);
      check("t6_timeout", timeout_err, 0);
      for (int i = 0; i < N; i++) check($sformatf("t6_ready%0d", i), cmres[i].ready, 0);
      owner = -1;
      rel = 0;
      ptr = 0;
      age = 0;
      want = 4'b1001;
      mode = 1;
      lat = 2;
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_obs();
      repeat (12) cycle();
      check("t6_first", (order.size() > 0) ? order[0] : -1, 0);
      check("t6_second", (order.size() > 1) ? order[1] : -1, 3);

      mode = 0;
      for (int n = 0; n < 800; n++) begin
         for (int i = 0; i < N; i++) begin
            if (!want[i] && $urandom_range(0, 2) == 0) want[i] = 1'b1;
            addr_v[i] = $urandom;
            data_v[i] = $urandom;
            rw_v[i] = 1'($urandom_range(0, 1));
         end
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
